// File: rtl/conv_unit_sequencer.sv
// Sequences bias and MAC beats from separate pixel/weight streams into a
// single registered output slot feeding the convolution unit.
module conv_unit_sequencer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned KERNEL_W_MAX = 3,
  parameter int unsigned TUSER_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] ONE_VALUE = DATA_WIDTH'(16'h3C00)
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [COUNT_WIDTH-1:0]               cfg_beats,
  input  logic [COUNT_WIDTH-1:0]               cfg_blocks,
  input  logic [2:0]                           cfg_user,
  input  logic                                 s_pix_valid,
  output logic                                 s_pix_ready,
  input  logic [DATA_WIDTH-1:0]                s_pix_data,
  input  logic                                 s_wt_valid,
  output logic                                 s_wt_ready,
  input  logic [KERNEL_W_MAX*DATA_WIDTH-1:0]   s_wt_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data_pixels,
  output logic [KERNEL_W_MAX*DATA_WIDTH-1:0]   m_data_weights,
  output logic                                 m_last,
  output logic [TUSER_WIDTH-1:0]               m_user,
  output logic                                 done
);

  localparam int unsigned WT_W = KERNEL_W_MAX * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIAS  = 2'd1,
    ST_MAC   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_beats;
  logic [COUNT_WIDTH-1:0] r_blocks;
  logic [2:0]             r_user;
  logic [COUNT_WIDTH-1:0] r_beat_cnt;
  logic [COUNT_WIDTH-1:0] r_blk_cnt;
  logic                   r_cfg_ready;
  logic                   r_done;
  logic                   r_m_valid;
  logic [DATA_WIDTH-1:0]  r_m_pix;
  logic [WT_W-1:0]        r_m_wt;
  logic                   r_m_last;
  logic [TUSER_WIDTH-1:0] r_m_user;

  logic                   w_slot_free;
  logic                   w_last_beat;
  logic                   w_last_blk;
  logic                   w_join;
  logic                   w_cfg_take;
  logic                   w_bias_xfer;
  logic                   w_mac_xfer;
  logic                   w_done_nxt;
  logic                   w_pix_rdy;
  logic                   w_wt_rdy;
  logic [TUSER_WIDTH-1:0] w_user;

  assign w_slot_free = !r_m_valid || m_ready;
  assign w_last_beat = (r_beat_cnt == (r_beats - COUNT_WIDTH'(1)));
  assign w_last_blk  = (r_blk_cnt == (r_blocks - COUNT_WIDTH'(1)));
  assign w_join      = s_pix_valid && s_wt_valid && w_slot_free;
  assign w_user      = TUSER_WIDTH'({w_last_blk, r_user});

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_take  = 1'b0;
    w_bias_xfer = 1'b0;
    w_mac_xfer  = 1'b0;
    w_done_nxt  = 1'b0;
    w_pix_rdy   = 1'b0;
    w_wt_rdy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          w_cfg_take  = 1'b1;
          w_state_nxt = ST_BIAS;
        end
      end
      ST_BIAS: begin
        w_wt_rdy = w_slot_free;
        if (s_wt_valid && w_slot_free) begin
          w_bias_xfer = 1'b1;
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        w_pix_rdy = w_join;
        w_wt_rdy  = w_join;
        if (w_join) begin
          w_mac_xfer = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = w_last_blk ? ST_FLUSH : ST_BIAS;
          end
        end
      end
      ST_FLUSH: begin
        if (w_slot_free) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, job configuration and counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_cfg_ready <= 1'b1;
      r_done      <= 1'b0;
      r_beats     <= '0;
      r_blocks    <= '0;
      r_user      <= '0;
      r_beat_cnt  <= '0;
      r_blk_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= w_done_nxt;
      if (w_cfg_take) begin
        // Zero-length fields would never terminate, so they run as length one
        r_beats    <= (cfg_beats == '0) ? COUNT_WIDTH'(1) : cfg_beats;
        r_blocks   <= (cfg_blocks == '0) ? COUNT_WIDTH'(1) : cfg_blocks;
        r_user     <= cfg_user;
        r_beat_cnt <= '0;
        r_blk_cnt  <= '0;
      end
      if (w_bias_xfer) begin
        r_beat_cnt <= '0;
      end
      if (w_mac_xfer) begin
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          if (!w_last_blk) begin
            r_blk_cnt <= r_blk_cnt + COUNT_WIDTH'(1);
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Single output slot; contents frozen while stalled
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_m_valid <= 1'b0;
      r_m_pix   <= '0;
      r_m_wt    <= '0;
      r_m_last  <= 1'b0;
      r_m_user  <= '0;
    end else if (w_bias_xfer || w_mac_xfer) begin
      r_m_valid <= 1'b1;
      r_m_pix   <= w_bias_xfer ? ONE_VALUE : s_pix_data;
      r_m_wt    <= s_wt_data;
      r_m_last  <= w_mac_xfer && w_last_beat;
      r_m_user  <= w_user;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign cfg_ready      = r_cfg_ready;
  assign done           = r_done;
  assign s_pix_ready    = w_pix_rdy;
  assign s_wt_ready     = w_wt_rdy;
  assign m_valid        = r_m_valid;
  assign m_data_pixels  = r_m_pix;
  assign m_data_weights = r_m_wt;
  assign m_last         = r_m_last;
  assign m_user         = r_m_user;

endmodule
